// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract unit: a CHUNK-bit full-adder ripple slice is reused
// NCHUNK = WIDTH/CHUNK times, with the carry held in a register between chunks.

module seq_chunk_adder_fa (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_co
);

  assign o_s  = i_a ^ i_b ^ i_c;
  assign o_co = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_sub,
  input  logic             i_cin,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf,
  output logic             o_state
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Handshake: i_start is sampled only in S_IDLE (o_busy=0); the accept edge
  // latches a/b/sub/cin. o_done pulses for one cycle when sum/cout/ovf update,
  // and that cycle is already S_IDLE, so a new start is accepted there.

  state_t            r_state;
  state_t            w_next_state;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic              r_c;
  logic [CW-1:0]     r_cnt;
  logic [WIDTH-1:0]  r_acc;
  logic [WIDTH-1:0]  r_sum;
  logic              r_cout;
  logic              r_ovf;
  logic              r_done;

  logic              w_accept;
  logic              w_last;
  int                w_base;
  logic [CHUNK-1:0]  w_ca;
  logic [CHUNK-1:0]  w_cb;
  logic [CHUNK-1:0]  w_s;
  logic [CHUNK:0]    w_c;
  logic [WIDTH-1:0]  w_res;

  assign w_accept = (r_state == S_IDLE) && i_start;
  assign w_last   = (r_state == S_RUN) && (r_cnt == CW'(NCHUNK - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next_state = S_RUN;
      S_RUN:   if (w_last)  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // The current chunk is selected by index instead of shifting the operands,
  // so the same slice works unchanged when CHUNK == WIDTH.
  assign w_base = int'(r_cnt) * CHUNK;
  assign w_ca   = r_a[w_base +: CHUNK];
  assign w_cb   = r_b[w_base +: CHUNK];
  assign w_c[0] = r_c;

  for (genvar g = 0; g < CHUNK; g++) begin : g_slice
    seq_chunk_adder_fa u_fa (
      .i_a  (w_ca[g]),
      .i_b  (w_cb[g]),
      .i_c  (w_c[g]),
      .o_s  (w_s[g]),
      .o_co (w_c[g+1])
    );
  end

  always_comb begin
    w_res = r_acc;
    w_res[w_base +: CHUNK] = w_s;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_c    <= 1'b0;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_a   <= i_a;
        r_b   <= i_sub ? ~i_b : i_b;
        r_c   <= i_sub ? 1'b1 : i_cin;
        r_cnt <= '0;
        r_acc <= '0;
      end else if (r_state == S_RUN) begin
        r_acc <= w_res;
        r_c   <= w_c[CHUNK];
        r_cnt <= r_cnt + CW'(1);
        if (w_last) begin
          // On the last chunk, w_c[CHUNK-1] is the carry into the word MSB.
          r_sum  <= w_res;
          r_cout <= w_c[CHUNK];
          r_ovf  <= w_c[CHUNK-1] ^ w_c[CHUNK];
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_busy  = (r_state == S_RUN);
  assign o_done  = r_done;
  assign o_sum   = r_sum;
  assign o_cout  = r_cout;
  assign o_ovf   = r_ovf;
  assign o_state = r_state;

endmodule
